sdes_iter_core: RTL and testbench

//   Iterative, parametrised S-DES-family block cipher engine with valid/ready streaming handshake.
//   - Performs one Feistel round per clock on an 8-bit block under a 10-bit key; encrypt or decrypt selected per block.
//   - Generalises the 2-round combinational SDES datapath to NUM_ROUNDS rounds.
//   - Sits between a byte producer (UART/host FIFO) and a byte consumer in the cipher subsystem.

---
 rtl/sdes_iter_core_if.sv | 22 ++
 rtl/sdes_iter_core.sv | 150 +++++++++++++++
 tb/tb_sdes_iter_core.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdes_iter_core_if.sv
// Streaming handshake bundle for sdes_iter_core: block/key/mode in, result block out.
// A transfer happens on a rising edge where valid and ready are both high; a raised valid holds its payload until that edge.
interface sdes_iter_core_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [9:0] in_key;
  logic       in_encrypt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_encrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_encrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sdes_iter_core.sv
// Iterative S-DES-family engine: one Feistel round per clock, NUM_ROUNDS rounds per block.
// Optional CBC chaining is compiled in with SDES_CBC_EN (adds iv_load/iv ports); default is pure ECB.
module sdes_iter_core #(
  parameter int NUM_ROUNDS = 2
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SDES_CBC_EN
  input  logic       iv_load,
  input  logic [7:0] iv,
`endif
  sdes_iter_core_if.slave bus
);

  localparam int RW = (NUM_ROUNDS > 2) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RW-1:0] LAST = RW'(NUM_ROUNDS - 1);

  // S-box entries indexed by {row, col}, row-major.
  localparam logic [1:0] S0_TBL [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                         2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1_TBL [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                         2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [RW-1:0] rnd;
  logic [7:0]    blk;
  logic [9:0]    key_q;
  logic          enc_q;
  logic [7:0]    out_q;
  logic          accept, last_rnd, iv_take;

  logic [RW-1:0] kidx;
  logic [2:0]    rot;
  logic [9:0]    p10, ls;
  logic [7:0]    subkey, ep, rnd_blk, result, cipher_in;
  logic [3:0]    sb, p4, left_new;

  function automatic logic [4:0] rotl5(input logic [4:0] x, input logic [2:0] s);
    case (s)
      3'd1:    rotl5 = {x[3:0], x[4]};
      3'd2:    rotl5 = {x[2:0], x[4:3]};
      3'd3:    rotl5 = {x[1:0], x[4:2]};
      3'd4:    rotl5 = {x[0], x[4:1]};
      default: rotl5 = x;
    endcase
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] d);
    ip = {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    ip_inv = {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

`ifdef SDES_CBC_EN
  logic [7:0] chain, ct_q;
  assign iv_take = iv_load;
`else
  assign iv_take = 1'b0;
`endif

  // An IV load in IDLE takes priority over a block, so ready drops for that cycle.
  assign bus.in_ready  = (state == IDLE) && !iv_take;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_rnd      = (rnd == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_rnd) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subkey i rotates each P10 half by (1+2i) mod 5; decrypt walks the schedule backwards.
  always_comb begin
    kidx      = enc_q ? rnd : LAST - rnd;
    rot       = 3'((1 + 2 * int'(kidx)) % 5);
    p10       = {key_q[7], key_q[5], key_q[8], key_q[3], key_q[6],
                 key_q[0], key_q[9], key_q[1], key_q[2], key_q[4]};
    ls        = {rotl5(p10[9:5], rot), rotl5(p10[4:0], rot)};
    subkey    = {ls[4], ls[7], ls[3], ls[6], ls[2], ls[5], ls[0], ls[1]};
    ep        = {blk[0], blk[3], blk[2], blk[1], blk[2], blk[1], blk[0], blk[3]} ^ subkey;
    sb        = {S0_TBL[{ep[7], ep[4], ep[6], ep[5]}], S1_TBL[{ep[3], ep[0], ep[2], ep[1]}]};
    p4        = {sb[2], sb[0], sb[1], sb[3]};
    left_new  = blk[7:4] ^ p4;
    rnd_blk   = last_rnd ? {left_new, blk[3:0]} : {blk[3:0], left_new};
    result    = ip_inv(rnd_blk);
    cipher_in = bus.in_data;
`ifdef SDES_CBC_EN
    if (!enc_q)         result    = result ^ chain;
    if (bus.in_encrypt) cipher_in = bus.in_data ^ chain;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd   <= '0;
      blk   <= '0;
      key_q <= '0;
      enc_q <= 1'b0;
      out_q <= '0;
`ifdef SDES_CBC_EN
      chain <= '0;
      ct_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            blk   <= ip(cipher_in);
            key_q <= bus.in_key;
            enc_q <= bus.in_encrypt;
            rnd   <= '0;
`ifdef SDES_CBC_EN
            ct_q  <= bus.in_data;
`endif
          end
`ifdef SDES_CBC_EN
          if (iv_load) chain <= iv;
`endif
        end
        RUN: begin
          blk <= rnd_blk;
          if (last_rnd) out_q <= result;
          else          rnd   <= rnd + RW'(1);
        end
        DONE: begin
`ifdef SDES_CBC_EN
          if (bus.out_ready) chain <= enc_q ? out_q : ct_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_iter_core.sv
// Directed bench for sdes_iter_core: classic S-DES vectors, handshake timing, reset, and
// multi-round round-trips on NUM_ROUNDS = 4 and 16 instances. CBC scenario built with SDES_CBC_EN.
module tb_sdes_iter_core;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdes_iter_core_if bus2 ();
  sdes_iter_core_if bus4 ();
  sdes_iter_core_if bus16a ();
  sdes_iter_core_if bus16b ();

`ifdef SDES_CBC_EN
  logic       iv_load;
  logic [7:0] iv;
  sdes_iter_core #(.NUM_ROUNDS(2))  dut2   (.clk(clk), .reset(reset), .iv_load(iv_load), .iv(iv), .bus(bus2));
  sdes_iter_core #(.NUM_ROUNDS(4))  dut4   (.clk(clk), .reset(reset), .iv_load(1'b0), .iv(8'h00), .bus(bus4));
  sdes_iter_core #(.NUM_ROUNDS(16)) dut16a (.clk(clk), .reset(reset), .iv_load(1'b0), .iv(8'h00), .bus(bus16a));
  sdes_iter_core #(.NUM_ROUNDS(16)) dut16b (.clk(clk), .reset(reset), .iv_load(1'b0), .iv(8'h00), .bus(bus16b));
`else
  sdes_iter_core #(.NUM_ROUNDS(2))  dut2   (.clk(clk), .reset(reset), .bus(bus2));
  sdes_iter_core #(.NUM_ROUNDS(4))  dut4   (.clk(clk), .reset(reset), .bus(bus4));
  sdes_iter_core #(.NUM_ROUNDS(16)) dut16a (.clk(clk), .reset(reset), .bus(bus16a));
  sdes_iter_core #(.NUM_ROUNDS(16)) dut16b (.clk(clk), .reset(reset), .bus(bus16b));
`endif

  localparam logic [9:0] KEY = 10'b1010000010;
  localparam logic [7:0] PT  = 8'b10010111;
  localparam logic [7:0] CT  = 8'b00111000;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] keys [8] = '{10'h282, 10'h000, 10'h3FF, 10'h155, 10'h2AA, 10'h1F3, 10'h0C7, 10'h36E};

  // Textbook S-DES tables (1-indexed bit positions, MSB = 1) for the reference model.
  int p10_t [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int p8_t  [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  int ip_t  [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  int ipi_t [10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  int ep_t  [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  int p4_t  [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  int s0_m [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int s1_m [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic logic [9:0] perm(input logic [9:0] x, input int win, input int t[10], input int wout);
    logic [9:0] y;
    y = '0;
    for (int j = 1; j <= wout; j++) y[wout - j] = x[win - t[j - 1]];
    return y;
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] k);
    logic [9:0] e, p;
    logic [3:0] s;
    e = perm({6'b0, x[3:0]}, 4, ep_t, 8);
    e[7:0] = e[7:0] ^ k;
    s[3:2] = 2'(s0_m[{e[7], e[4]}][{e[6], e[5]}]);
    s[1:0] = 2'(s1_m[{e[3], e[0]}][{e[2], e[1]}]);
    p = perm({6'b0, s}, 4, p4_t, 4);
    return {x[7:4] ^ p[3:0], x[3:0]};
  endfunction

  function automatic logic [7:0] ref_sdes(input logic [7:0] d, input logic [9:0] key, input logic enc);
    logic [9:0] p10, t;
    logic [4:0] l, r;
    logic [7:0] k1, k2, b;
    p10 = perm(key, 10, p10_t, 10);
    l = {p10[8:5], p10[9]};
    r = {p10[3:0], p10[4]};
    t = perm({l, r}, 10, p8_t, 8);
    k1 = t[7:0];
    l = {l[2:0], l[4:3]};
    r = {r[2:0], r[4:3]};
    t = perm({l, r}, 10, p8_t, 8);
    k2 = t[7:0];
    t = perm({2'b0, d}, 8, ip_t, 8);
    b = fk(t[7:0], enc ? k1 : k2);
    b = fk({b[3:0], b[7:4]}, enc ? k2 : k1);
    t = perm({2'b0, b}, 8, ipi_t, 8);
    return t[7:0];
  endfunction

  task automatic idle_bus(virtual sdes_iter_core_if vif);
    vif.in_valid   = 1'b0;
    vif.in_data    = 8'h00;
    vif.in_key     = 10'h000;
    vif.in_encrypt = 1'b0;
    vif.out_ready  = 1'b0;
  endtask

  task automatic clear_chain();
`ifdef SDES_CBC_EN
    iv_load = 1'b1;
    iv      = 8'h00;
    @(negedge clk);
    iv_load = 1'b0;
`endif
  endtask

  // Starts and ends on a falling edge; lat = rising edges from accept to out_valid.
  task automatic do_block(virtual sdes_iter_core_if vif, input logic [7:0] d, input logic [9:0] k,
                          input logic e, output logic [7:0] res, output int lat);
    int n = 0;
    vif.in_valid   = 1'b1;
    vif.in_data    = d;
    vif.in_key     = k;
    vif.in_encrypt = e;
    vif.out_ready  = 1'b1;
    while (vif.in_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    vif.in_valid = 1'b0;
    lat = 0;
    while (vif.out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    res = vif.out_data;
    @(negedge clk);
    vif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus2.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus2.in_ready); else n_pass++;
    n_checks++; if (bus2.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus2.out_valid); else n_pass++;
    n_checks++; if (bus2.out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", bus2.out_data); else n_pass++;
    n_checks++; if (bus16a.in_ready !== 1'b1) $display("FAIL reset_in_ready_n16: got %b expected 1", bus16a.in_ready); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_encrypt();
    logic [7:0] res;
    int lat;
    clear_chain();
    do_block(bus2, PT, KEY, 1'b1, res, lat);
    n_checks++; if (res !== CT) $display("FAIL enc_classic: got %h expected %h", res, CT); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL enc_latency: got %0d expected 2", lat); else n_pass++;
  endtask

  task automatic test_decrypt();
    clear_chain();
    bus2.in_valid = 1'b1; bus2.in_data = CT; bus2.in_key = KEY; bus2.in_encrypt = 1'b0; bus2.out_ready = 1'b0;
    #1;
    n_checks++; if (bus2.in_ready !== 1'b1) $display("FAIL dec_ready_before: got %b expected 1", bus2.in_ready); else n_pass++;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    n_checks++; if (bus2.in_ready !== 1'b0) $display("FAIL dec_ready_run: got %b expected 0", bus2.in_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus2.out_valid !== 1'b0) $display("FAIL dec_valid_early: got %b expected 0", bus2.out_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus2.out_valid !== 1'b1) $display("FAIL dec_valid: got %b expected 1", bus2.out_valid); else n_pass++;
    n_checks++; if (bus2.out_data !== PT) $display("FAIL dec_classic: got %h expected %h", bus2.out_data, PT); else n_pass++;
    n_checks++; if (bus2.in_ready !== 1'b0) $display("FAIL dec_ready_done: got %b expected 0", bus2.in_ready); else n_pass++;
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
    n_checks++; if (bus2.out_valid !== 1'b0) $display("FAIL dec_valid_drop: got %b expected 0", bus2.out_valid); else n_pass++;
    n_checks++; if (bus2.in_ready !== 1'b1) $display("FAIL dec_ready_after: got %b expected 1", bus2.in_ready); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_chain();
    bus2.in_valid = 1'b1; bus2.in_data = PT; bus2.in_key = KEY; bus2.in_encrypt = 1'b1; bus2.out_ready = 1'b0;
    @(negedge clk);
    bus2.in_data = 8'h55;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus2.out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus2.out_valid); else n_pass++;
      n_checks++; if (bus2.out_data !== CT) $display("FAIL hold_data[%0d]: got %h expected %h", i, bus2.out_data, CT); else n_pass++;
      n_checks++; if (bus2.in_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b expected 0", i, bus2.in_ready); else n_pass++;
      @(negedge clk);
    end
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
    n_checks++; if (bus2.out_valid !== 1'b0) $display("FAIL hold_release_valid: got %b expected 0", bus2.out_valid); else n_pass++;
    n_checks++; if (bus2.in_ready !== 1'b1) $display("FAIL hold_release_ready: got %b expected 1", bus2.in_ready); else n_pass++;
    bus2.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc_q[$];
    int n_out = 0;
    bus2.in_valid = 1'b1; bus2.in_data = PT; bus2.in_key = KEY; bus2.in_encrypt = 1'b1; bus2.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus2.in_ready === 1'b1) acc_q.push_back(c);
      if (bus2.out_valid === 1'b1) n_out++;
      @(negedge clk);
    end
    idle_bus(bus2);
    n_checks++; if (acc_q.size() != 4) $display("FAIL b2b_accepts: got %0d expected 4", acc_q.size()); else n_pass++;
    n_checks++; if (n_out != 4) $display("FAIL b2b_outputs: got %0d expected 4", n_out); else n_pass++;
    for (int i = 1; i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] - acc_q[i - 1] != 4) $display("FAIL b2b_period[%0d]: got %0d expected 4", i, acc_q[i] - acc_q[i - 1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int lat;
    bus2.in_valid = 1'b1; bus2.in_data = 8'h3C; bus2.in_key = KEY; bus2.in_encrypt = 1'b1; bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (bus2.out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", bus2.out_valid); else n_pass++;
    n_checks++; if (bus2.in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", bus2.in_ready); else n_pass++;
    n_checks++; if (bus2.out_data !== 8'h00) $display("FAIL rst_mid_data: got %h expected 00", bus2.out_data); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (bus2.out_valid !== 1'b0) $display("FAIL rst_mid_no_output[%0d]: got %b expected 0", i, bus2.out_valid); else n_pass++;
    end
    do_block(bus2, PT, KEY, 1'b1, res, lat);
    n_checks++; if (res !== CT) $display("FAIL rst_mid_next: got %h expected %h", res, CT); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL rst_mid_latency: got %0d expected 2", lat); else n_pass++;
  endtask

  task automatic test_vectors();
    logic [7:0] pts [5] = '{8'h97, 8'h00, 8'hFF, 8'h5A, 8'hC3};
    logic [9:0] ks  [5] = '{10'h282, 10'h000, 10'h3FF, 10'h1F3, 10'h2AA};
    logic [7:0] res, exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      exp = ref_sdes(pts[i], ks[i], 1'b1);
      clear_chain();
      do_block(bus2, pts[i], ks[i], 1'b1, res, lat);
      n_checks++; if (res !== exp) $display("FAIL vec_enc[%0d]: got %h expected %h", i, res, exp); else n_pass++;
      clear_chain();
      do_block(bus2, exp, ks[i], 1'b0, res, lat);
      n_checks++; if (res !== pts[i]) $display("FAIL vec_dec[%0d]: got %h expected %h", i, res, pts[i]); else n_pass++;
    end
  endtask

  task automatic test_cbc();
`ifdef SDES_CBC_EN
    logic [7:0] pts [3] = '{8'h12, 8'h97, 8'hF0};
    logic [7:0] cts [3];
    logic [7:0] prev, exp, res;
    int lat;
    iv_load = 1'b1; iv = 8'hA5;
    @(negedge clk);
    iv_load = 1'b0;
    prev = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      exp = ref_sdes(pts[i] ^ prev, KEY, 1'b1);
      do_block(bus2, pts[i], KEY, 1'b1, res, lat);
      n_checks++; if (res !== exp) $display("FAIL cbc_enc[%0d]: got %h expected %h", i, res, exp); else n_pass++;
      cts[i] = exp;
      prev = exp;
    end
    bus2.in_valid = 1'b1; bus2.in_data = cts[0]; bus2.in_key = KEY; bus2.in_encrypt = 1'b0;
    iv_load = 1'b1; iv = 8'hA5;
    #1;
    n_checks++; if (bus2.in_ready !== 1'b0) $display("FAIL cbc_iv_priority: got %b expected 0", bus2.in_ready); else n_pass++;
    @(negedge clk);
    iv_load = 1'b0;
    bus2.in_valid = 1'b0;
    n_checks++; if (bus2.in_ready !== 1'b1) $display("FAIL cbc_no_accept: got %b expected 1", bus2.in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      do_block(bus2, cts[i], KEY, 1'b0, res, lat);
      n_checks++; if (res !== pts[i]) $display("FAIL cbc_dec[%0d]: got %h expected %h", i, res, pts[i]); else n_pass++;
    end
`endif
  endtask

  task automatic test_roundtrip(virtual sdes_iter_core_if vif, input int nr, input int k_lo, input int k_hi);
    logic [7:0] ct, pt2;
    int lat;
    for (int k = k_lo; k <= k_hi; k++) begin
      for (int p = 0; p < 256; p++) begin
        do_block(vif, 8'(p), keys[k], 1'b1, ct, lat);
        n_checks++; if (lat != nr) $display("FAIL rt_enc_latency N=%0d key=%h pt=%h: got %0d expected %0d", nr, keys[k], p, lat, nr); else n_pass++;
        do_block(vif, ct, keys[k], 1'b0, pt2, lat);
        n_checks++; if (lat != nr) $display("FAIL rt_dec_latency N=%0d key=%h pt=%h: got %0d expected %0d", nr, keys[k], p, lat, nr); else n_pass++;
        n_checks++; if (pt2 !== 8'(p)) $display("FAIL rt_plain N=%0d key=%h: got %h expected %h", nr, keys[k], pt2, 8'(p)); else n_pass++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
`ifdef SDES_CBC_EN
    iv_load = 1'b0;
    iv      = 8'h00;
`endif
    idle_bus(bus2);
    idle_bus(bus4);
    idle_bus(bus16a);
    idle_bus(bus16b);
    @(negedge clk);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_vectors();
    test_cbc();
    fork
      test_roundtrip(bus4, 4, 0, 7);
      test_roundtrip(bus16a, 16, 0, 3);
      test_roundtrip(bus16b, 16, 4, 7);
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
